// File: rtl/lh_ecdsa_sched_pkg.sv
// Scheduler-local types and helpers.
package lh_ecdsa_sched_pkg;

    import meta_package::*;

    localparam int unsigned NUM_Q = 2;

    typedef logic [LH_ECDSA_BUF_PTR_NBITS-1:0] buf_ptr_t;

    // Queue index to one-hot pop strobe.
    function automatic logic [NUM_Q-1:0] q_onehot(input logic q);
        return q ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/meta_package.sv
// Shared descriptor layout for the ECDSA metadata FIFOs and the scheduler.
package meta_package;

    localparam int unsigned LH_ECDSA_BUF_PTR_NBITS = 10;
    localparam int unsigned LH_ECDSA_KEY_NBITS     = 4;
    localparam int unsigned LH_ECDSA_LEN_NBITS     = 16;

    typedef struct packed {
        logic                              discard;
        logic [LH_ECDSA_KEY_NBITS-1:0]     key_id;
        logic [LH_ECDSA_LEN_NBITS-1:0]     msg_len;
        logic [LH_ECDSA_BUF_PTR_NBITS-1:0] buf_ptr;
    } lh_ecdsa_meta_type;

    localparam int unsigned LH_ECDSA_META_NBITS = $bits(lh_ecdsa_meta_type);

endpackage

// File: rtl/lh_ecdsa_sched_if.sv
// FIFO read side plus engine and buffer-manager handshakes of the scheduler.
interface lh_ecdsa_sched_if;

    logic [1:0]                                      q_empty;
    logic [1:0]                                      q_rd;
    meta_package::lh_ecdsa_meta_type                 q0_dout;
    meta_package::lh_ecdsa_meta_type                 q1_dout;
    logic                                            meta_valid;
    meta_package::lh_ecdsa_meta_type                 meta;
    logic                                            meta_ready;
    logic                                            free_valid;
    logic [meta_package::LH_ECDSA_BUF_PTR_NBITS-1:0] free_ptr;
    logic                                            free_ready;

    modport master (
        input  q_empty, q0_dout, q1_dout, meta_ready, free_ready,
        output q_rd, meta_valid, meta, free_valid, free_ptr
    );

    modport slave (
        output q_empty, q0_dout, q1_dout, meta_ready, free_ready,
        input  q_rd, meta_valid, meta, free_valid, free_ptr
    );

endinterface

// File: rtl/lh_ecdsa_sched_sel.sv
// Weighted-priority pick: queue 0 first, queue 1 after HI_WEIGHT consecutive queue-0 wins.
module lh_ecdsa_sched_sel #(
    parameter int unsigned HI_WEIGHT    = 4,
    parameter int unsigned HI_RUN_NBITS = 3
) (
    input  logic [1:0]              q_empty,
    input  logic [HI_RUN_NBITS-1:0] hi_run,
    output logic                    any_c,
    output logic                    grant_c,
    output logic [HI_RUN_NBITS-1:0] hi_run_nxt_c
);

    always_comb begin
        any_c   = ~&q_empty;
        grant_c = q_empty[0] | (~q_empty[1] & (hi_run == HI_RUN_NBITS'(HI_WEIGHT)));
        // The run only counts queue-0 wins that actually held queue 1 off.
        if (grant_c || q_empty[1]) begin
            hi_run_nxt_c = '0;
        end else begin
            hi_run_nxt_c = hi_run + HI_RUN_NBITS'(1);
        end
    end

endmodule

// File: rtl/lh_ecdsa_sched.sv
// Pops one descriptor at a time from two metadata FIFOs and either forwards it
// to the ECDSA engine or asks the buffer manager to free its buffer.
module lh_ecdsa_sched
    import meta_package::*;
    import lh_ecdsa_sched_pkg::*;
#(
    parameter int unsigned HI_WEIGHT = 4,
    parameter int unsigned CNT_NBITS = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    lh_ecdsa_sched_if.master     bus,
    output logic [CNT_NBITS-1:0] pass_cnt,
    output logic [CNT_NBITS-1:0] drop_cnt
);

    localparam int unsigned HI_RUN_NBITS = (HI_WEIGHT < 1) ? 1 : $clog2(HI_WEIGHT + 1);

    typedef enum logic [1:0] {IDLE, LOAD, OUT, DROP} state_t;

    state_t                  state, state_d;
    logic                    sel, sel_d;
    logic [HI_RUN_NBITS-1:0] hi_run, hi_run_d;
    logic [1:0]              q_rd, q_rd_d;
    logic                    meta_valid, meta_valid_d;
    logic                    free_valid, free_valid_d;
    lh_ecdsa_meta_type       meta, meta_d;
    buf_ptr_t                free_ptr, free_ptr_d;
    logic [CNT_NBITS-1:0]    pass_cnt_d, drop_cnt_d;

    logic                    any_c;
    logic                    grant_c;
    logic [HI_RUN_NBITS-1:0] hi_run_nxt_c;

    lh_ecdsa_sched_sel #(
        .HI_WEIGHT    (HI_WEIGHT),
        .HI_RUN_NBITS (HI_RUN_NBITS)
    ) u_sel (
        .q_empty      (bus.q_empty),
        .hi_run       (hi_run),
        .any_c        (any_c),
        .grant_c      (grant_c),
        .hi_run_nxt_c (hi_run_nxt_c)
    );

    // Next state and next values of every registered output.
    always_comb begin
        state_d      = state;
        sel_d        = sel;
        hi_run_d     = hi_run;
        q_rd_d       = '0;
        meta_valid_d = meta_valid;
        free_valid_d = free_valid;
        meta_d       = meta;
        free_ptr_d   = free_ptr;
        pass_cnt_d   = pass_cnt;
        drop_cnt_d   = drop_cnt;
        case (state)
            IDLE: begin
                if (enable && any_c) begin
                    state_d  = LOAD;
                    sel_d    = grant_c;
                    hi_run_d = hi_run_nxt_c;
                    q_rd_d   = q_onehot(grant_c);
                end
            end
            LOAD: begin
                // The FIFO head is still the popped entry on this edge.
                meta_d = sel ? bus.q1_dout : bus.q0_dout;
                if (meta_d.discard) begin
                    free_valid_d = 1'b1;
                    free_ptr_d   = meta_d.buf_ptr;
                    state_d      = DROP;
                end else begin
                    meta_valid_d = 1'b1;
                    state_d      = OUT;
                end
            end
            OUT: begin
                if (bus.meta_ready) begin
                    meta_valid_d = 1'b0;
                    state_d      = IDLE;
                    if (pass_cnt != '1) pass_cnt_d = pass_cnt + CNT_NBITS'(1);
                end
            end
            DROP: begin
                if (bus.free_ready) begin
                    free_valid_d = 1'b0;
                    state_d      = IDLE;
                    if (drop_cnt != '1) drop_cnt_d = drop_cnt + CNT_NBITS'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sel        <= 1'b0;
            hi_run     <= '0;
            q_rd       <= '0;
            meta_valid <= 1'b0;
            free_valid <= 1'b0;
            meta       <= '0;
            free_ptr   <= '0;
            pass_cnt   <= '0;
            drop_cnt   <= '0;
        end else begin
            state      <= state_d;
            sel        <= sel_d;
            hi_run     <= hi_run_d;
            q_rd       <= q_rd_d;
            meta_valid <= meta_valid_d;
            free_valid <= free_valid_d;
            meta       <= meta_d;
            free_ptr   <= free_ptr_d;
            pass_cnt   <= pass_cnt_d;
            drop_cnt   <= drop_cnt_d;
        end
    end

    assign bus.q_rd       = q_rd;
    assign bus.meta_valid = meta_valid;
    assign bus.meta       = meta;
    assign bus.free_valid = free_valid;
    assign bus.free_ptr   = free_ptr;

endmodule

// File: tb/tb_lh_ecdsa_sched.sv
// Bench for lh_ecdsa_sched: FIFO model, handshake monitor and a queue-level reference model.
module tb_lh_ecdsa_sched;

    import meta_package::*;

    localparam int unsigned HI_W  = 4;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned BPW   = LH_ECDSA_BUF_PTR_NBITS;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enable;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] drop_cnt;

    lh_ecdsa_sched_if bus ();

    lh_ecdsa_sched #(
        .HI_WEIGHT (HI_W),
        .CNT_NBITS (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .bus      (bus.master),
        .pass_cnt (pass_cnt),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    // FIFO model with registered empty flags and head registers.
    lh_ecdsa_meta_type fq0[$];
    lh_ecdsa_meta_type fq1[$];
    logic [1:0]        push_en;
    lh_ecdsa_meta_type push_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fq0.delete();
            fq1.delete();
            bus.q_empty <= 2'b11;
            bus.q0_dout <= '0;
            bus.q1_dout <= '0;
        end else begin
            if (bus.q_rd[0] && fq0.size() > 0) void'(fq0.pop_front());
            if (bus.q_rd[1] && fq1.size() > 0) void'(fq1.pop_front());
            if (push_en[0]) fq0.push_back(push_data);
            if (push_en[1]) fq1.push_back(push_data);
            bus.q_empty <= {fq1.size() == 0, fq0.size() == 0};
            bus.q0_dout <= (fq0.size() > 0) ? fq0[0] : '0;
            bus.q1_dout <= (fq1.size() > 0) ? fq1[0] : '0;
        end
    end

    // Monitor: grants, completed handshakes and protocol violations.
    int                grant_log[$];
    lh_ecdsa_meta_type acc_meta[$];
    logic [BPW-1:0]    acc_free[$];
    int                viol = 0;
    int                mv_cycles = 0;
    int                qrd_cycles = 0;

    always @(negedge clk) begin
        if (bus.q_rd == 2'b01) grant_log.push_back(0);
        if (bus.q_rd == 2'b10) grant_log.push_back(1);
        if (bus.q_rd == 2'b11) viol <= viol + 1;
        if (bus.meta_valid && bus.free_valid) viol <= viol + 1;
        if (bus.meta_valid) mv_cycles <= mv_cycles + 1;
        if (bus.q_rd != 2'b00) qrd_cycles <= qrd_cycles + 1;
        if (bus.meta_valid && bus.meta_ready) acc_meta.push_back(bus.meta);
        if (bus.free_valid && bus.free_ready) acc_free.push_back(bus.free_ptr);
    end

    // Reference model state.
    lh_ecdsa_meta_type mq0[$];
    lh_ecdsa_meta_type mq1[$];
    int                exp_grant[$];
    lh_ecdsa_meta_type exp_meta[$];
    logic [BPW-1:0]    exp_free[$];
    int unsigned       m_hi = 0;
    int                m_pass = 0;
    int                m_drop = 0;
    int                cg = 0, cm = 0, cf = 0;
    int                tests = 0;
    int                fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic lh_ecdsa_meta_type rand_desc(input logic disc);
        lh_ecdsa_meta_type d;
        d.discard = disc;
        d.key_id  = LH_ECDSA_KEY_NBITS'($urandom);
        d.msg_len = LH_ECDSA_LEN_NBITS'($urandom);
        d.buf_ptr = BPW'($urandom);
        return d;
    endfunction

    function automatic int sat(input int n);
        int top;
        top = (1 << CNT_W) - 1;
        return (n > top) ? top : n;
    endfunction

    task automatic push(input int q, input lh_ecdsa_meta_type d);
        push_data = d;
        push_en   = (q == 0) ? 2'b01 : 2'b10;
        tick();
        push_en   = 2'b00;
        if (q == 0) mq0.push_back(d);
        else mq1.push_back(d);
    endtask

    // Serve everything queued in the model by the weighted-priority rule.
    task automatic model_drain();
        while (mq0.size() > 0 || mq1.size() > 0) begin
            int q;
            lh_ecdsa_meta_type d;
            q = (mq1.size() > 0 && (mq0.size() == 0 || m_hi == HI_W)) ? 1 : 0;
            if (q == 1) begin
                m_hi = 0;
                d = mq1.pop_front();
            end else begin
                m_hi = (mq1.size() > 0) ? m_hi + 1 : 0;
                d = mq0.pop_front();
            end
            exp_grant.push_back(q);
            if (d.discard) begin
                exp_free.push_back(d.buf_ptr);
                m_drop++;
            end else begin
                exp_meta.push_back(d);
                m_pass++;
            end
        end
    endtask

    task automatic wait_done(input bit rnd);
        int target = exp_meta.size() + exp_free.size();
        int n = 0;
        while ((acc_meta.size() + acc_free.size()) < target && n < 2000) begin
            if (rnd) begin
                bus.meta_ready = 1'($urandom);
                bus.free_ready = 1'($urandom);
                enable         = ($urandom_range(0, 3) != 0);
            end
            tick();
            n++;
        end
        bus.meta_ready = 1'b1;
        bus.free_ready = 1'b1;
        enable         = 1'b1;
        tick();
        tick();
        chk("drain_in_budget", 64'(n < 2000), 64'(1));
    endtask

    task automatic compare_logs();
        chk("grant_count", 64'(grant_log.size()), 64'(exp_grant.size()));
        chk("meta_count", 64'(acc_meta.size()), 64'(exp_meta.size()));
        chk("free_count", 64'(acc_free.size()), 64'(exp_free.size()));
        for (int i = cg; i < exp_grant.size() && i < grant_log.size(); i++)
            chk("grant_order", 64'(grant_log[i]), 64'(exp_grant[i]));
        for (int i = cm; i < exp_meta.size() && i < acc_meta.size(); i++)
            chk("meta_data", 64'(acc_meta[i]), 64'(exp_meta[i]));
        for (int i = cf; i < exp_free.size() && i < acc_free.size(); i++)
            chk("free_ptr_data", 64'(acc_free[i]), 64'(exp_free[i]));
        cg = exp_grant.size();
        cm = exp_meta.size();
        cf = exp_free.size();
        chk("pass_cnt", 64'(pass_cnt), 64'(sat(m_pass)));
        chk("drop_cnt", 64'(drop_cnt), 64'(sat(m_drop)));
    endtask

    initial begin
        lh_ecdsa_meta_type d1, d2;
        int n, n0, n1;

        rst_n          = 1'b0;
        enable         = 1'b0;
        bus.meta_ready = 1'b0;
        bus.free_ready = 1'b0;
        push_en        = 2'b00;
        push_data      = '0;
        repeat (3) @(posedge clk);
        #1;

        // Reset values.
        chk("rst_q_rd", 64'(bus.q_rd), 64'(0));
        chk("rst_meta_valid", 64'(bus.meta_valid), 64'(0));
        chk("rst_free_valid", 64'(bus.free_valid), 64'(0));
        chk("rst_meta", 64'(bus.meta), 64'(0));
        chk("rst_free_ptr", 64'(bus.free_ptr), 64'(0));
        chk("rst_pass_cnt", 64'(pass_cnt), 64'(0));
        chk("rst_drop_cnt", 64'(drop_cnt), 64'(0));
        rst_n = 1'b1;
        tick();

        // Single queue-0 descriptor: pop in cycle 2, offer in cycle 3.
        enable         = 1'b1;
        bus.meta_ready = 1'b1;
        bus.free_ready = 1'b1;
        d1 = rand_desc(1'b0);
        push(0, d1);
        @(negedge clk);
        chk("c1_not_empty", 64'(bus.q_empty[0]), 64'(0));
        chk("c1_no_rd", 64'(bus.q_rd), 64'(0));
        @(negedge clk);
        chk("c2_q_rd", 64'(bus.q_rd), 64'(2'b01));
        @(negedge clk);
        chk("c3_meta", 64'({bus.meta_valid, bus.meta}), 64'({1'b1, d1}));
        @(negedge clk);
        chk("c4_pass_cnt", 64'(pass_cnt), 64'(1));
        chk("c4_meta_valid", 64'(bus.meta_valid), 64'(0));
        tick();
        model_drain();
        compare_logs();

        // Queue-1 discard with free_ready held low for 4 cycles.
        bus.free_ready = 1'b0;
        d1 = rand_desc(1'b1);
        d1.buf_ptr = BPW'(12'h1A5);
        n = mv_cycles;
        push(1, d1);
        n0 = 0;
        do begin
            @(negedge clk);
            n0++;
        end while (!bus.free_valid && n0 < 10);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            chk("drop_hold", 64'({bus.free_valid, bus.free_ptr}), 64'({1'b1, BPW'(12'h1A5)}));
        end
        tick();
        bus.free_ready = 1'b1;
        @(negedge clk);
        chk("drop_accept_cycle", 64'(bus.free_valid), 64'(1));
        tick();
        @(negedge clk);
        chk("drop_released", 64'(bus.free_valid), 64'(0));
        chk("drop_cnt_one", 64'(drop_cnt), 64'(1));
        chk("drop_no_meta_valid", 64'(mv_cycles - n), 64'(0));
        tick();
        model_drain();
        compare_logs();

        // 20-cycle stall in OUT with a second entry waiting and enable toggling.
        bus.meta_ready = 1'b0;
        d1 = rand_desc(1'b0);
        push(0, d1);
        n0 = 0;
        do begin
            @(negedge clk);
            n0++;
        end while (!bus.meta_valid && n0 < 10);
        tick();
        d2 = rand_desc(1'b0);
        push(0, d2);
        n = qrd_cycles;
        for (int k = 0; k < 20; k++) begin
            enable = 1'($urandom);
            @(negedge clk);
            chk("stall_meta_stable", 64'({bus.meta_valid, bus.meta}), 64'({1'b1, d1}));
            tick();
        end
        chk("stall_no_q_rd", 64'(qrd_cycles - n), 64'(0));
        enable         = 1'b1;
        bus.meta_ready = 1'b1;
        model_drain();
        wait_done(1'b0);
        compare_logs();

        // Both queues preloaded with 10 entries: weighted grant order.
        enable = 1'b0;
        for (int k = 0; k < 10; k++) begin
            push(0, rand_desc(1'($urandom)));
            push(1, rand_desc(1'($urandom)));
        end
        tick();
        model_drain();
        enable = 1'b1;
        wait_done(1'b0);
        compare_logs();

        // Random occupancy with random back-pressure and enable gaps.
        for (int r = 0; r < 4; r++) begin
            enable = 1'b0;
            n0 = $urandom_range(0, 7);
            n1 = $urandom_range(1, 7);
            for (int k = 0; k < n0; k++) push(0, rand_desc(1'($urandom)));
            for (int k = 0; k < n1; k++) push(1, rand_desc(1'($urandom)));
            tick();
            model_drain();
            wait_done(1'b1);
            compare_logs();
        end

        // Reset during DROP: outputs clear at once, the popped entry is lost.
        enable         = 1'b1;
        bus.free_ready = 1'b0;
        push(1, rand_desc(1'b1));
        n0 = 0;
        do begin
            @(negedge clk);
            n0++;
        end while (!bus.free_valid && n0 < 10);
        chk("pre_reset_drop", 64'(bus.free_valid), 64'(1));
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valids", 64'({bus.q_rd, bus.meta_valid, bus.free_valid}), 64'(0));
        chk("arst_meta", 64'(bus.meta), 64'(0));
        chk("arst_free_ptr", 64'(bus.free_ptr), 64'(0));
        chk("arst_counts", 64'({pass_cnt, drop_cnt}), 64'(0));
        model_drain();
        void'(exp_free.pop_back());
        m_pass = 0;
        m_drop = 0;
        m_hi   = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n          = 1'b1;
        bus.free_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("post_reset_idle", 64'({bus.q_rd, bus.meta_valid, bus.free_valid}), 64'(0));
            tick();
        end
        compare_logs();

        // 17 forwarded descriptors with 4-bit counters: pass_cnt sticks at 15.
        enable = 1'b0;
        for (int k = 0; k < 17; k++) push(0, rand_desc(1'b0));
        tick();
        model_drain();
        enable = 1'b1;
        wait_done(1'b0);
        compare_logs();
        chk("pass_cnt_saturated", 64'(pass_cnt), 64'(15));

        chk("protocol_violations", 64'(viol), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
